// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-add-3, one bit per clock).
// Start/done handshake; bcd/overflow hold the last completed result.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   adj_c;
  logic               ovf_acc;
  logic [CNT_W-1:0]   cnt;

  // Add-3 correction on every digit >= 5 before the shift; 5..9 maps to 8..12, no wrap.
  always_comb begin
    adj_c = scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adj_c[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      ovf_acc   <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            scratch   <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= CNT_W'(BIN_W);
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // The bit leaving the top digit means the value no longer fits in DIGITS digits.
          {scratch, shift_reg} <= {adj_c[BCD_W-2:0], shift_reg, 1'b0};
          ovf_acc              <= ovf_acc | adj_c[BCD_W-1];
          cnt                  <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd      <= scratch;
          overflow <= ovf_acc;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: 3-digit and 2-digit instances driven in parallel,
// checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W = 8;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy3, done3, ovf3;
  logic [11:0] bcd3;
  logic        busy2, done2, ovf2;
  logic [7:0]  bcd2;

  int checks = 0;
  int errors = 0;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value modulo 10^digits written as decimal digits, overflow if it does not fit.
  function automatic logic [11:0] model_bcd(input int v, input int digits);
    int p;
    int r;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    r = v % p;
    return {4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  function automatic logic model_ovf(input int v, input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return v >= p;
  endfunction

  // One conversion; lat counts edges after the accepting edge until done is seen.
  task automatic run_one(input logic [7:0] v, output int lat, output int busy_cnt,
                         output logic [11:0] b3, output logic o3,
                         output logic [7:0] b2, output logic o2);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin   = 8'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done3 && lat < 40) begin
      if (busy3) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    b3 = bcd3; o3 = ovf3; b2 = bcd2; o2 = ovf2;
  endtask

  task automatic check_conv(input string name, input logic [7:0] v);
    int lat, bc;
    logic [11:0] b3;
    logic [7:0]  b2;
    logic o3, o2;
    run_one(v, lat, bc, b3, o3, b2, o2);
    checks++;
    if (lat !== 9) begin
      errors++; $display("FAIL %s latency bin=%0d: got %0d, expected 9", name, v, lat);
    end
    checks++;
    if (b3 !== model_bcd(int'(v), 3) || o3 !== model_ovf(int'(v), 3)) begin
      errors++;
      $display("FAIL %s d3 bin=%0d: got bcd=%h ovf=%b, expected bcd=%h ovf=%b",
               name, v, b3, o3, model_bcd(int'(v), 3), model_ovf(int'(v), 3));
    end
    checks++;
    if ({4'h0, b2} !== model_bcd(int'(v), 2) || o2 !== model_ovf(int'(v), 2)) begin
      errors++;
      $display("FAIL %s d2 bin=%0d: got bcd=%h ovf=%b, expected bcd=%h ovf=%b",
               name, v, b2, o2, model_bcd(int'(v), 2), model_ovf(int'(v), 2));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bin = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || bcd3 !== 12'h000 || ovf3 !== 1'b0) begin
      errors++; $display("FAIL reset d3: got busy=%b done=%b bcd=%h ovf=%b, expected 0 0 000 0",
                         busy3, done3, bcd3, ovf3);
    end
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || bcd2 !== 8'h00 || ovf2 !== 1'b0) begin
      errors++; $display("FAIL reset d2: got busy=%b done=%b bcd=%h ovf=%b, expected 0 0 00 0",
                         busy2, done2, bcd2, ovf2);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero();
    int lat, bc;
    logic [11:0] b3;
    logic [7:0]  b2;
    logic o3, o2;
    run_one(8'd0, lat, bc, b3, o3, b2, o2);
    checks++;
    if (lat !== 9 || bc !== 9) begin
      errors++; $display("FAIL zero timing: got latency=%0d busy_cycles=%0d, expected 9 9", lat, bc);
    end
    checks++;
    if (b3 !== 12'h000 || o3 !== 1'b0 || busy3 !== 1'b0) begin
      errors++; $display("FAIL zero result: got bcd=%h ovf=%b busy=%b, expected 000 0 0", b3, o3, busy3);
    end
    @(negedge clk);
    checks++;
    if (done3 !== 1'b0) begin
      errors++; $display("FAIL zero pulse width: got done=%b a cycle later, expected 0", done3);
    end
  endtask

  task automatic test_directed();
    check_conv("dir255", 8'd255);
    check_conv("dir99",  8'd99);
    check_conv("dir100", 8'd100);
    check_conv("dir200", 8'd200);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) check_conv("rand", 8'($urandom));
  endtask

  task automatic test_ignore_start();
    int ndone;
    @(negedge clk);
    bin = 8'd37; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bin = 8'd0;
    @(negedge clk);
    @(negedge clk);
    bin = 8'd200; start = 1'b1;   // sampled at edge k+3 while busy
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int t = 0; t < 30; t++) begin
      if (done3) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 1 || bcd3 !== 12'h037) begin
      errors++; $display("FAIL ignore_start: got dones=%0d bcd=%h, expected 1 037", ndone, bcd3);
    end
  endtask

  task automatic test_back_to_back();
    int t_done[2];
    logic [11:0] v_done[2];
    int n;
    @(negedge clk);
    bin = 8'd12; start = 1'b1;
    @(negedge clk);
    bin = 8'd34;
    n = 0;
    for (int t = 0; t < 40 && n < 2; t++) begin
      if (done3) begin
        t_done[n] = t; v_done[n] = bcd3; n++;
        if (n == 2) start = 1'b0;
      end
      if (n < 2) @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL b2b count: got %0d done pulses, expected 2", n);
    end else begin
      checks++;
      if (v_done[0] !== 12'h012 || v_done[1] !== 12'h034) begin
        errors++; $display("FAIL b2b values: got %h then %h, expected 012 then 034", v_done[0], v_done[1]);
      end
      checks++;
      // accept edge, BIN_W shift edges, done edge, then re-accept in the IDLE cycle
      if (t_done[1] - t_done[0] !== int'(BIN_W) + 2) begin
        errors++; $display("FAIL b2b spacing: got %0d clocks, expected %0d",
                           t_done[1] - t_done[0], BIN_W + 2);
      end
    end
    for (int t = 0; t < 20 && busy3; t++) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    bin = 8'd150; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || bcd3 !== 12'h000 || ovf3 !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b bcd=%h ovf=%b, expected 0 0 000 0",
                         busy3, done3, bcd3, ovf3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int t = 0; t < 15; t++) begin
      if (done3 || busy3) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone !== 0) begin
      errors++; $display("FAIL reset_mid abort: got %0d active cycles after reset, expected 0", ndone);
    end
    check_conv("after_reset", 8'd150);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
